hilo_bypass_file: RTL
=====================

Name: hilo_bypass_file

Overview:
- Architectural HI/LO register pair with a parametrised forwarding network serving several read ports (dual-issue decode).
- Tracks outstanding multi-cycle mult/div operations and stalls HI/LO readers until the result is available.
- Sits between decode (readers) and the execute/memory/writeback stages (forward sources), replacing the single-port combinational HI/LO forward.

Parameters:
- NUM_SRC, 6: forward sources; index 0 is the youngest stage and has the highest priority.
- NUM_READ, 2: decode read ports.
- DATA_W, 32: HI and LO width.
- MAX_PEND, 3: maximum in-flight mult/div operations (counter range 0..MAX_PEND).

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- src_valid_hi  in  NUM_SRC  per-source HI write valid.
- src_valid_lo  in  NUM_SRC  per-source LO write valid.
- src_hi  in  NUM_SRC x DATA_W  per-source HI value.
- src_lo  in  NUM_SRC x DATA_W  per-source LO value.
- wb_valid_hi  in  1  commit HI write.
- wb_valid_lo  in  1  commit LO write.
- wb_hi  in  DATA_W  commit HI value.
- wb_lo  in  DATA_W  commit LO value.
- md_issue  in  1  mult/div launched this cycle.
- md_done  in  1  mult/div result retiring this cycle.
- flush  in  1  pipeline flush; squashes in-flight mult/div.
- rd_req  in  NUM_READ  port reads HI or LO this cycle.
- rd_hi  out  NUM_READ x DATA_W  forwarded HI.
- rd_lo  out  NUM_READ x DATA_W  forwarded LO.
- rd_stall  out  1  a requesting port must hold.
- md_full  out  1  pending count == MAX_PEND.
- pend_cnt  out  $clog2(MAX_PEND+1)  current pending count.

Behaviour:
- Reset (async on resetn low): HI=0, LO=0, pend_cnt=0, md_full=0. rd_stall=0 while pend_cnt=0. Any mult/div in progress is discarded.
- HI/LO registers: updated on the rising edge when wb_valid_hi / wb_valid_lo is set, each half independently. The new value is visible from the register the next cycle.
- Forwarding is combinational and applied per port, with HI and LO resolved independently. For each half, priority order is:
  - lowest-index source with its valid set;
  - otherwise the same-cycle wb value, if its wb_valid is set;
  - otherwise the register.
- All read ports see identical values. rd_hi/rd_lo are driven even when rd_req=0.
- Pending counter next value:
  - flush: next = md_issue (an issue in the flush cycle belongs to the post-flush stream); md_done is ignored.
  - otherwise: next = pend_cnt + md_issue - md_done.
  - issue and done in the same cycle: count unchanged.
  - done with count 0: ignored, count stays 0.
  - issue with count == MAX_PEND: ignored, count saturates; simulation assertion error.
- rd_stall = |rd_req && pend_cnt != 0. This is registered-count based, so a result retiring this cycle via md_done/source forwarding still stalls one cycle. Decode re-reads next cycle and gets the value from the forward path.
- md_full = (pend_cnt == MAX_PEND). Issue logic must not assert md_issue while md_full is set.
- No further internal latency: reads are zero-cycle, writes take one cycle.

Optional Feature:
- HILO_ACC_EN adds ports acc_valid (1), acc_sub (1), acc_val (2*DATA_W) for madd/msub.
- When acc_valid is set at commit, {HI,LO} <= {HI,LO} + acc_val, or - acc_val if acc_sub, with 2*DATA_W wrap-around. This has priority over wb_valid_*.
- The accumulated result is forwarded same-cycle, at the wb priority level.
- Without HILO_ACC_EN the ports and adder are absent and the commit path is plain write.

Decomposition:
- Shared package:
  - write_hilo_t: valid_hi, valid_lo, hi, lo;
  - pend_cnt width function;
  - MAX_PEND default constant.
- Sub-module hilo_fwd_mux: one half, NUM_SRC-way priority select plus wb/register fallback. It is instantiated twice (HI, LO) and its output is fanned out to NUM_READ ports.

Test Plan:
- Reset then rd_req=01 with no writes -> rd_hi=rd_lo=0, rd_stall=0.
- src_valid_hi[2]=1 (hi=0xAAAA0000) and src_valid_hi[4]=1 (hi=0xBBBB0000), src_valid_lo[5]=1 (lo=0x5) -> rd_hi=0xAAAA0000 and rd_lo=0x5 on both ports.
- wb_valid_lo=1, wb_lo=0x1234 -> same cycle rd_lo=0x1234 via bypass; next cycle with no sources, rd_lo=0x1234 from the register; HI unchanged.
- md_issue x3 -> pend_cnt=3, md_full=1; rd_req=10 gives rd_stall=1. issue+done together keeps count 3. Three md_done pulses -> count 0, stall drops the cycle after the last done.
- pend_cnt=2, then flush with md_issue=1 in the same cycle -> pend_cnt=1. Then flush with md_done=1 -> pend_cnt=0.
- (HILO_ACC_EN) HI=0, LO=0xFFFFFFFF, acc_valid=1, acc_val=1 -> HI=1, LO=0. Then acc_sub=1, acc_val=2 -> HI=0, LO=0xFFFFFFFE.

Source files
------------

// File: rtl/hilo_bypass_file_pkg.sv
// Shared types and sizing helpers for the HI/LO bypass file.
package hilo_bypass_file_pkg;

    localparam int HILO_DATA_W   = 32;
    localparam int HILO_MAX_PEND = 3;

    // Commit-stage write to the architectural pair; sized to the architectural width.
    typedef struct packed {
        logic                   valid_hi;
        logic                   valid_lo;
        logic [HILO_DATA_W-1:0] hi;
        logic [HILO_DATA_W-1:0] lo;
    } write_hilo_t;

    function automatic int pend_cnt_w(input int max_pend);
        return (max_pend < 1) ? 1 : $clog2(max_pend + 1);
    endfunction

endpackage

// File: rtl/hilo_bypass_file_chk.sv
// Protocol checks for the HI/LO bypass file (issue-side back-pressure).
module hilo_bypass_file_chk (
    input logic clk,
    input logic resetn,
    input logic md_issue,
    input logic md_done,
    input logic flush,
    input logic md_full
);

    // A launch while full would be dropped; only a same-cycle retire or flush makes room.
    assert property (@(posedge clk) disable iff (!resetn)
        !(md_issue && md_full && !md_done && !flush))
        else $error("hilo_bypass_file: md_issue asserted while md_full");

endmodule

// File: rtl/hilo_fwd_mux.sv
// One HI or LO half: lowest-index valid source wins, then the commit value, then the register.
module hilo_fwd_mux #(
    parameter int NUM_SRC = 6,
    parameter int DATA_W  = 32
) (
    input  logic [NUM_SRC-1:0]             src_valid_i,
    input  logic [NUM_SRC-1:0][DATA_W-1:0] src_data_i,
    input  logic                           wb_valid_i,
    input  logic [DATA_W-1:0]              wb_data_i,
    input  logic [DATA_W-1:0]              reg_data_i,
    output logic [DATA_W-1:0]              data_o
);

    logic              found_s;
    logic [DATA_W-1:0] src_sel_s;

    // Priority search over forward sources, with commit/register fallback.
    always_comb begin
        found_s   = 1'b0;
        src_sel_s = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!found_s && src_valid_i[i]) begin
                found_s   = 1'b1;
                src_sel_s = src_data_i[i];
            end else begin
                found_s   = found_s;
            end
        end
        if (found_s) begin
            data_o = src_sel_s;
        end else if (wb_valid_i) begin
            data_o = wb_data_i;
        end else begin
            data_o = reg_data_i;
        end
    end

endmodule

// File: rtl/hilo_bypass_file.sv
// HI/LO register pair with multi-source forwarding and mult/div pending tracking.
// Optional madd/msub commit path is enabled by defining HILO_ACC_EN.
module hilo_bypass_file
    import hilo_bypass_file_pkg::*;
#(
    parameter int NUM_SRC  = 6,
    parameter int NUM_READ = 2,
    parameter int DATA_W   = HILO_DATA_W,
    parameter int MAX_PEND = HILO_MAX_PEND
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic [NUM_SRC-1:0]                src_valid_hi,
    input  logic [NUM_SRC-1:0]                src_valid_lo,
    input  logic [NUM_SRC-1:0][DATA_W-1:0]    src_hi,
    input  logic [NUM_SRC-1:0][DATA_W-1:0]    src_lo,
    input  logic                              wb_valid_hi,
    input  logic                              wb_valid_lo,
    input  logic [DATA_W-1:0]                 wb_hi,
    input  logic [DATA_W-1:0]                 wb_lo,
`ifdef HILO_ACC_EN
    input  logic                              acc_valid,
    input  logic                              acc_sub,
    input  logic [2*DATA_W-1:0]               acc_val,
`endif
    input  logic                              md_issue,
    input  logic                              md_done,
    input  logic                              flush,
    input  logic [NUM_READ-1:0]               rd_req,
    output logic [NUM_READ-1:0][DATA_W-1:0]   rd_hi,
    output logic [NUM_READ-1:0][DATA_W-1:0]   rd_lo,
    output logic                              rd_stall,
    output logic                              md_full,
    output logic [pend_cnt_w(MAX_PEND)-1:0]   pend_cnt
);

    localparam int                PEND_W   = pend_cnt_w(MAX_PEND);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PEND);

    write_hilo_t       commit_s;
    logic [DATA_W-1:0] hi_q, lo_q;
    logic [DATA_W-1:0] fwd_hi_s, fwd_lo_s;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              full_q;
`ifdef HILO_ACC_EN
    logic [2*DATA_W-1:0] acc_sum_s;
`endif

    // Resolve the commit-stage write; an accumulate overrides plain writes.
    always_comb begin
        commit_s = '0;
`ifdef HILO_ACC_EN
        if (acc_sub) begin
            acc_sum_s = {hi_q, lo_q} - acc_val;
        end else begin
            acc_sum_s = {hi_q, lo_q} + acc_val;
        end
        if (acc_valid) begin
            commit_s.valid_hi = 1'b1;
            commit_s.valid_lo = 1'b1;
            commit_s.hi       = acc_sum_s[2*DATA_W-1:DATA_W];
            commit_s.lo       = acc_sum_s[DATA_W-1:0];
        end else begin
            commit_s.valid_hi = wb_valid_hi;
            commit_s.valid_lo = wb_valid_lo;
            commit_s.hi       = wb_hi;
            commit_s.lo       = wb_lo;
        end
`else
        commit_s.valid_hi = wb_valid_hi;
        commit_s.valid_lo = wb_valid_lo;
        commit_s.hi       = wb_hi;
        commit_s.lo       = wb_lo;
`endif
    end

    // Architectural HI/LO registers; each half commits independently.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (commit_s.valid_hi) hi_q <= commit_s.hi;
            if (commit_s.valid_lo) lo_q <= commit_s.lo;
        end
    end

    hilo_fwd_mux #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W)) u_fwd_hi (
        .src_valid_i (src_valid_hi),
        .src_data_i  (src_hi),
        .wb_valid_i  (commit_s.valid_hi),
        .wb_data_i   (commit_s.hi),
        .reg_data_i  (hi_q),
        .data_o      (fwd_hi_s)
    );

    hilo_fwd_mux #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W)) u_fwd_lo (
        .src_valid_i (src_valid_lo),
        .src_data_i  (src_lo),
        .wb_valid_i  (commit_s.valid_lo),
        .wb_data_i   (commit_s.lo),
        .reg_data_i  (lo_q),
        .data_o      (fwd_lo_s)
    );

    for (genvar g = 0; g < NUM_READ; g++) begin : g_rd
        assign rd_hi[g] = fwd_hi_s;
        assign rd_lo[g] = fwd_lo_s;
    end

    // Pending mult/div count: a flush restarts from the flush-cycle issue only.
    always_comb begin
        pend_d = pend_q;
        if (flush) begin
            pend_d = {{(PEND_W-1){1'b0}}, md_issue};
        end else if (md_issue && !md_done) begin
            if (pend_q == PEND_MAX) begin
                pend_d = pend_q;
            end else begin
                pend_d = pend_q + {{(PEND_W-1){1'b0}}, 1'b1};
            end
        end else if (md_done && !md_issue) begin
            if (pend_q == '0) begin
                pend_d = pend_q;
            end else begin
                pend_d = pend_q - {{(PEND_W-1){1'b0}}, 1'b1};
            end
        end else begin
            pend_d = pend_q;
        end
    end

    // Pending count and full flag registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend_q <= '0;
            full_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            full_q <= (pend_d == PEND_MAX);
        end
    end

    // Stall is based on the registered count, so a same-cycle retire still holds decode once.
    assign rd_stall = (|rd_req) && (pend_q != '0);
    assign md_full  = full_q;
    assign pend_cnt = pend_q;

    hilo_bypass_file_chk u_chk (
        .clk      (clk),
        .resetn   (resetn),
        .md_issue (md_issue),
        .md_done  (md_done),
        .flush    (flush),
        .md_full  (md_full)
    );

endmodule
